// File: rtl/handshake_pkg.sv
// ----------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the four-phase receive FIFO:
//   DEFAULT_B   default data word width
//   hs_state_t  handshake FSM state (IDLE: ack low, ACKED: ack high)
// ----------------------------------------------------------------------------
package handshake_pkg;

   localparam int DEFAULT_B = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      ACKED = 1'b1
   } hs_state_t;

endpackage

// File: rtl/handshake_rx_fifo_sync.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single-bit level crossing into clk.
// Ports:
//   clk  sampling clock
//   rst  synchronous active-high reset, clears both flops to 0
//   d    asynchronous input level
//   q    synchronized level (second flop)
// ----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic sync_p0;

   // stage p0 may go metastable; stage p1 (q) is the only safe consumer tap
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         q       <= 1'b0;
      end else begin
         sync_p0 <= d;
         q       <= sync_p0;
      end
   end

endmodule

// File: rtl/handshake_rx_fifo.sv
// ----------------------------------------------------------------------------
// handshake_rx_fifo
// Receives words from an asynchronous four-phase (rqst/ack) sender and stores
// them in a first-word-fall-through FIFO for a synchronous consumer.
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   rqst       four-phase request from the sender (asynchronous)
//   BusData    bundled data, stable while rqst is high
//   ack        four-phase acknowledge, registered
//   rd_en      consumer pop request
//   OutData    head-of-FIFO word, 0 when empty
//   out_valid  FIFO non-empty
//   full       count == DEPTH
//   count      number of stored words
// ----------------------------------------------------------------------------
module handshake_rx_fifo
   import handshake_pkg::*;
#(
   parameter int B     = DEFAULT_B,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rqst,
   input  logic [B-1:0]             BusData,
   output logic                     ack,
   input  logic                     rd_en,
   output logic [B-1:0]             OutData,
   output logic                     out_valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          rqst_s;
   hs_state_t     state;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [B-1:0]  mem [DEPTH];
   logic          wr_go;
   logic          rd_go;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rqst),
      .q   (rqst_s)
   );

   // full comes from the registered count, so a same-edge pop never frees a
   // slot for a write while full; the sender simply waits on ack.
   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign wr_go     = (state == IDLE) && rqst_s && !full;
   assign rd_go     = rd_en && out_valid;
   assign OutData   = out_valid ? mem[rd_ptr] : '0;

   // handshake FSM: one write per four-phase cycle, ack registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ack   <= 1'b0;
      end else if (state == IDLE) begin
         if (wr_go) begin
            state <= ACKED;
            ack   <= 1'b1;
         end
      end else begin
         if (!rqst_s) begin
            state <= IDLE;
            ack   <= 1'b0;
         end
      end
   end

   // storage: data only, no reset
   always_ff @(posedge clk) begin
      if (wr_go && !rst) begin
         mem[wr_ptr] <= BusData;
      end
   end

   // pointers and occupancy; power-of-two DEPTH makes the pointer wrap free
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_go) wr_ptr <= wr_ptr + PW'(1);
         if (rd_go) rd_ptr <= rd_ptr + PW'(1);
         if (wr_go && !rd_go)      count <= count + CW'(1);
         else if (rd_go && !wr_go) count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_handshake_rx_fifo.sv
module tb_handshake_rx_fifo;

   localparam int B     = 16;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         rqst;
   logic [B-1:0] BusData;
   logic         ack;
   logic         rd_en;
   logic [B-1:0] OutData;
   logic         out_valid;
   logic         full;
   logic [2:0]   count;

   int checks   = 0;
   int failures = 0;
   logic [B-1:0] sbq [$];

   handshake_rx_fifo #(.B(B), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .rqst      (rqst),
      .BusData   (BusData),
      .ack       (ack),
      .rd_en     (rd_en),
      .OutData   (OutData),
      .out_valid (out_valid),
      .full      (full),
      .count     (count)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endfunction

   // scoreboard monitor: every accepted pop must present the next expected word
   initial begin
      logic [B-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst && rd_en && out_valid) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_unexpected actual=%0h expected=none", OutData);
            end else begin
               e = sbq.pop_front();
               check("pop_data", OutData, e);
            end
         end
      end
   end

   // wait until ack == lvl, returning edges taken; expired bound is a failure
   task automatic wait_ack(input logic lvl, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (ack !== lvl && n < 40);
      if (ack !== lvl) check("ack_timeout", ack, lvl);
   endtask

   task automatic handshake(input logic [B-1:0] d);
      int n;
      BusData = d;
      sbq.push_back(d);
      rqst = 1'b1;
      wait_ack(1'b1, n);
      check("ack_rise_lat", n, 3);
      rqst = 1'b0;
      wait_ack(1'b0, n);
      check("ack_fall_lat", n, 3);
      @(posedge clk); #2;
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      @(posedge clk); #2;
      rd_en = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (out_valid && k < 20) begin
         rd_en = 1'b1;
         @(posedge clk); #2;
         k++;
      end
      rd_en = 1'b0;
      check("drain_count", count, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; rqst = 1'b0; BusData = '0; rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", ack, 0);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", OutData, 0);
      #1 rst = 1'b0;
      @(posedge clk); #2;

      // single transfer
      BusData = 16'h0001; sbq.push_back(16'h0001); rqst = 1'b1;
      wait_ack(1'b1, n);
      check("single_rise_lat", n, 3);
      check("single_count", count, 1);
      check("single_data", OutData, 16'h0001);
      rqst = 1'b0;
      wait_ack(1'b0, n);
      check("single_fall_lat", n, 3);
      @(posedge clk); #2;
      drain();

      // fill beyond depth: fifth ack withheld until a pop
      for (int i = 1; i <= 4; i++) begin
         handshake(16'(i));
         check("fill_count", count, i);
      end
      check("fill_full", full, 1);
      BusData = 16'h0005; sbq.push_back(16'h0005); rqst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("bp_ack", ack, 0);
      check("bp_count", count, 4);
      check("bp_head", OutData, 16'h0001);
      #1;
      pop1();
      wait_ack(1'b1, n);
      check("bp_release_count", count, 4);
      check("bp_release_full", full, 1);
      rqst = 1'b0;
      wait_ack(1'b0, n);
      @(posedge clk); #2;
      drain();

      // wrap: write then pop, ten times
      for (int i = 1; i <= 10; i++) begin
         handshake(16'(i));
         pop1();
      end
      check("wrap_count", count, 0);

      // simultaneous write and pop at count=1
      handshake(16'h00AA);
      BusData = 16'h00BB; sbq.push_back(16'h00BB); rqst = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      rd_en = 1'b1;
      @(posedge clk); #1;
      check("sim_ack", ack, 1);
      check("sim_count", count, 1);
      check("sim_data", OutData, 16'h00BB);
      #1 rd_en = 1'b0;
      rqst = 1'b0;
      wait_ack(1'b0, n);
      @(posedge clk); #2;
      drain();

      // reset while ACKED with rqst held high
      BusData = 16'h0055; rqst = 1'b1;
      wait_ack(1'b1, n);
      check("pre_rst_count", count, 1);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("acked_rst_ack", ack, 0);
      check("acked_rst_count", count, 0);
      check("acked_rst_data", OutData, 0);
      #1 rst = 1'b0;
      sbq.push_back(16'h0055);
      wait_ack(1'b1, n);
      check("recap_lat", n, 3);
      check("recap_count", count, 1);
      check("recap_data", OutData, 16'h0055);
      rqst = 1'b0;
      wait_ack(1'b0, n);
      @(posedge clk); #2;
      drain();

      // pop while empty
      rd_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("empty_pop_count", count, 0);
      check("empty_pop_valid", out_valid, 0);
      check("empty_pop_data", OutData, 0);
      #1 rd_en = 1'b0;

      @(posedge clk); #2;
      check("sb_leftover", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
